// File: rtl/demux_1x2_tdm.sv
// demux_1x2_tdm: two-channel time-division demultiplexer.
// Routes each accepted word to one of two per-channel FIFOs by its select tag
// and flags violations of strict tag alternation with a registered pulse.
// Optional build macro DEMUX_ERRCNT_EN adds a saturating 8-bit violation
// counter on port err_count.
module demux_1x2_tdm #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             seq_err
`ifdef DEMUX_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        EXP0 = 2'd1,
        EXP1 = 2'd2
    } seq_state_t;

    seq_state_t state, state_next;
    logic       err_next;
    logic       accept;
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;
    logic [WIDTH-1:0] head [2];

    assign out_ready = {out1_ready, out0_ready};

    // Input handshake: readiness depends only on the selected FIFO's fill state.
    always_comb begin
        in_ready = !full[in_sel];
        accept   = in_valid && in_ready;
        push     = '0;
        push[0]  = accept && !in_sel;
        push[1]  = accept && in_sel;
        pop      = ~empty & out_ready;
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [AW:0]      count;

        assign full[c]  = (count == FULL_COUNT);
        assign empty[c] = (count == '0);
        assign head[c]  = mem[rd_ptr];

        // Per-channel FIFO storage, pointers (wrap modulo DEPTH) and occupancy.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[c]) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[c], pop[c]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];

    // Sequence FSM state register and registered violation pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SYNC;
            seq_err <= 1'b0;
        end else begin
            state   <= state_next;
            seq_err <= err_next;
        end
    end

    // Next-state and violation detection; a mismatch resyncs by staying put.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        if (accept) begin
            case (state)
                SYNC:    state_next = in_sel ? EXP0 : EXP1;
                EXP0: begin
                    if (in_sel) err_next   = 1'b1;
                    else        state_next = EXP1;
                end
                EXP1: begin
                    if (!in_sel) err_next   = 1'b1;
                    else         state_next = EXP0;
                end
                default: state_next = SYNC;
            endcase
        end
    end

`ifdef DEMUX_ERRCNT_EN
    // Saturating violation counter, aligned with the seq_err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_next && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_tdm.sv
// Testbench for demux_1x2_tdm: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_demux_1x2_tdm;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic             seq_err;
`ifdef DEMUX_ERRCNT_EN
    logic [7:0]       err_count;
`endif

    always #5 clk = ~clk;

    demux_1x2_tdm #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .seq_err    (seq_err)
`ifdef DEMUX_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    // Reference model: one queue per channel, last-tag expectation, error pulse, count.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               exp_tag;   // -1: no expectation yet, else tag expected next
    logic             m_err;
    int               m_cnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        exp_tag = -1;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic [WIDTH-1:0] d, input logic r0, input logic r1);
        logic acc, p0, p1, room;
        rst        = r;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        room = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        check_eq("in_ready", 32'(in_ready), 32'(room));
        check_eq("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
        check_eq("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
        if (q0.size() > 0) check_eq("out0_data", 32'(out0_data), 32'(q0[0]));
        if (q1.size() > 0) check_eq("out1_data", 32'(out1_data), 32'(q1[0]));
        check_eq("seq_err", 32'(seq_err), 32'(m_err));
`ifdef DEMUX_ERRCNT_EN
        check_eq("err_count", 32'(err_count), 32'(m_cnt));
`endif
        acc = v && room;
        p0  = (q0.size() > 0) && r0;
        p1  = (q1.size() > 0) && r1;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            m_err = 1'b0;
            if (acc) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
                m_err   = (exp_tag >= 0) && (int'(s) != exp_tag);
                exp_tag = s ? 0 : 1;
                if (m_err && m_cnt < 255) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        logic s;
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        // Reset values, including cleared storage at the FIFO heads.
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out0_data", 32'(out0_data), 32'd0);
        check_eq("rst_out1_data", 32'(out1_data), 32'd0);
        check_eq("rst_seq_err", 32'(seq_err), 32'd0);

        // Alternating beats with both consumers ready.
        step(1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        check_eq("alt_out0_11", 32'(out0_data), 32'h11);
        step(1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        check_eq("alt_out1_22", 32'(out1_data), 32'h22);
        step(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
        check_eq("alt_out0_33", 32'(out0_data), 32'h33);
        idle(2);

        // Fill channel 0 with its consumer stalled, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
        check_eq("full_in_ready_sel0", 32'(in_ready), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Tag sequence 0,0,1,1 from SYNC: two violations.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1);
        idle(2);

        // Channel 1 holding two words, simultaneous push/pop, then pointer wrap.
        step(1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'(i), 8'hD0 + 8'(i), 1'(i), 1'(~i));
        idle(DEPTH + 2);

        // Reset with both FIFOs partly full and the FSM expecting tag 1.
        step(1'b0, 1'b1, 1'b1, 8'h51, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0);
        do_reset();
        check_eq("mid_rst_out0_valid", 32'(out0_valid), 32'd0);
        check_eq("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 1'b1, 8'h61, 1'b1, 1'b1);
        check_eq("post_rst_seq_err", 32'(seq_err), 32'd0);
        idle(2);

        // Randomized traffic, mostly alternating tags, occasional reset.
        s = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) != 0) s = ~s;
            step(($urandom_range(63) == 0), 1'($urandom), s, 8'($urandom),
                 ($urandom_range(3) != 0), ($urandom_range(3) != 0));
        end
        idle(DEPTH + 2);

`ifdef DEMUX_ERRCNT_EN
        // Counter saturation on a long run of identical tags.
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
        idle(1);
        check_eq("err_count_sat", 32'(err_count), 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1x2_tdm.md
# demux_1x2_tdm

Two-channel time-division demultiplexer, the receive-side counterpart of the team's 2:1 mux. It accepts one tagged word stream and routes each word to one of two output channels by its select tag. Each channel has its own FIFO with a valid/ready handshake. A small FSM checks that the select tag strictly alternates and flags any sequence violation. The block sits between a shared link and two independent downstream consumers.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, per-channel FIFO depth; power of two, ≥2
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  muxed input word
- in_sel  input  1  destination tag: 0 → channel 0, 1 → channel 1
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block can accept the beat currently presented
- out0_data  output  WIDTH  channel 0 head word
- out0_valid  output  1  channel 0 FIFO non-empty
- out0_ready  input  1  channel 0 consumer accepts
- out1_data / out1_valid / out1_ready  same as channel 0, for channel 1
- seq_err  output  1  one-cycle pulse on a tag-alternation violation
- err_count  output  8  saturating violation count (present only with DEMUX_ERRCNT_EN)

## Operation
- Beat accepted when in_valid && in_ready. Word written to the FIFO selected by in_sel.
- in_ready = !full[in_sel]. Combinational on in_sel and registered FIFO state only; never depends on out*_ready.
- Pop on outN_valid && outN_ready. outN_data = FIFO head; outN_valid = !emptyN.
- FIFO: read/write pointers of log2(DEPTH) bits, wrap modulo DEPTH. Count of log2(DEPTH)+1 bits, range 0..DEPTH.
- Full FIFO: write blocked even if a pop happens in the same cycle (no full pass-through).
- Empty FIFO: a push and a pop cannot coincide, because outN_valid is 0.
- Non-full, non-empty FIFO: simultaneous push and pop is legal and the count is unchanged.
- Sequence FSM, states SYNC, EXP0, EXP1. Updates only on accepted beats.
  - SYNC: any tag → EXP(!tag), no error.
  - EXP0: tag 0 → EXP1. Tag 1 → seq_err, stay EXP0 (resync to opposite of received tag).
  - EXP1: tag 1 → EXP0. Tag 0 → seq_err, stay EXP1.
- Mismatched beats are still routed normally; no data is ever dropped.

## Timing
- Reset values:
  - in_ready 1
  - out0_valid, out1_valid 0
  - out0_data, out1_data 0 (storage cleared)
  - seq_err 0, err_count 0
  - FSM = SYNC, all pointers and counts 0
- Latency: word accepted in cycle N is visible on outN_data with outN_valid=1 in cycle N+1.
- seq_err is registered: it pulses in cycle N+1 for a violating beat accepted in cycle N.
- Back-to-back violations hold seq_err high for consecutive cycles.
- in_ready drops in the cycle after the DEPTH-th unpopped push to that channel. It rises in the cycle after the first pop from the full FIFO.
- Reset mid-operation discards all buffered words, FSM returns to SYNC, and outputs take their reset values in the cycle after rst is sampled high.

## Configuration
- DEMUX_ERRCNT_EN defined:
  - err_count port and 8-bit counter present.
  - Counter increments once per violation in the same cycle seq_err asserts.
  - Saturates at 255; cleared only by rst.
- Not defined: port and counter absent; seq_err behaviour unchanged.

## Test plan
- Reset, then alternating beats 0x11(sel0), 0x22(sel1), 0x33(sel0) with both readys high → out0 gives 0x11 then 0x33, out1 gives 0x22, each one cycle after acceptance; seq_err never asserts.
- out0_ready=0, push DEPTH(4) words 0xA0..0xA3 to channel 0 → in_ready=0 whenever in_sel=0 after the 4th push, still 1 when in_sel=1. Release out0_ready → words drain in order 0xA0..0xA3 and in_ready returns the cycle after the first pop.
- From SYNC send sel 0, 0, 1, 1 → seq_err pulses after the 2nd and 4th beats; all four words are delivered; err_count=2 with DEMUX_ERRCNT_EN.
- With a channel-1 FIFO holding 2 words, push and pop channel 1 in the same cycle → count stays 2 and the head advances correctly; pointers wrap after 6 more mixed operations.
- Assert rst while both FIFOs are partly full and the FSM is in EXP1 → next cycle both out*_valid=0, in_ready=1, FSM=SYNC; the next beat with sel=1 gives no seq_err.
- DEMUX_ERRCNT_EN build: 300 consecutive sel=0 beats with both readys high → err_count saturates at 255.
